// File: rtl/add_sched_pkg.sv
// Shared definitions for the shared-adder scheduler.
// - state_t : scheduler FSM states
// - DEF_*   : default parameter values
// - id_w()  : index width for a count of n items (never below 1 bit)
package add_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int DEF_NREQ  = 32'sd4;
    localparam int DEF_WIDTH = 32'sd4;
    localparam int DEF_LAT   = 32'sd2;

    function automatic int id_w(input int n);
        return (n > 32'sd1) ? $clog2(n) : 32'sd1;
    endfunction

endpackage

// File: rtl/add_unit.sv
// Pipelined WIDTH-bit adder with LAT register stages.
// Ports:
// - clk, rst : clock, asynchronous active-high reset
// - a, b     : operands (sampled every cycle)
// - res      : {carry,sum} of the operands presented LAT cycles earlier
module add_unit
    import add_sched_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LAT   = DEF_LAT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH:0]   res
);

    logic [WIDTH:0] pipe_r [LAT];

    // Stage 0 holds the zero-extended sum; later stages shift it toward the output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) begin
                pipe_r[i] <= '0;
            end
        end else begin
            pipe_r[0] <= {1'b0, a} + {1'b0, b};
            for (int i = 1; i < LAT; i++) begin
                pipe_r[i] <= pipe_r[i-1];
            end
        end
    end

    assign res = pipe_r[LAT-1];

endmodule

// File: rtl/add_share_sched.sv
// Round-robin scheduler sharing one pipelined adder among NREQ requesters.
// Ports:
// - clk, rst            : clock, asynchronous active-high reset
// - req_valid/a/b       : per-requester operand pairs, requester i at [i*WIDTH +: WIDTH]
// - req_ready           : one-hot accept pulse, only ever high in IDLE
// - rsp_valid/rsp_ready : response handshake
// - rsp_sum/carry/id    : result and index of the requester served, held until accepted
// - busy                : high whenever the scheduler is not IDLE
module add_share_sched
    import add_sched_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int WIDTH = DEF_WIDTH,
    parameter int LAT   = DEF_LAT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    output logic [NREQ-1:0]         req_ready,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [WIDTH-1:0]        rsp_sum,
    output logic                    rsp_carry,
    output logic [id_w(NREQ)-1:0]   rsp_id,
    output logic                    busy
);

    localparam int ID_W  = id_w(NREQ);
    localparam int CNT_W = id_w(LAT);

    state_t            state_r;
    state_t            state_nxt_s;
    logic [ID_W-1:0]   ptr_r;
    logic [ID_W-1:0]   id_r;
    logic [WIDTH-1:0]  a_r;
    logic [WIDTH-1:0]  b_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              rsp_valid_r;
    logic [ID_W-1:0]   scan_s [NREQ];
    logic [ID_W-1:0]   win_s;
    logic              any_s;
    logic [WIDTH:0]    res_s;

    // Candidate indices in priority order: ptr, ptr+1, ... wrapping at NREQ
    always_comb begin
        for (int k = 0; k < NREQ; k++) begin
            scan_s[k] = ID_W'((int'(ptr_r) + k) % NREQ);
        end
    end

    // Walk from lowest priority to highest so the first valid candidate is the one kept
    always_comb begin
        win_s = '0;
        any_s = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            win_s = req_valid[scan_s[k]] ? scan_s[k] : win_s;
            any_s = any_s | req_valid[scan_s[k]];
        end
    end

    // Next-state logic and the combinational accept pulse
    always_comb begin
        state_nxt_s = state_r;
        req_ready   = '0;
        case (state_r)
            IDLE: begin
                if (any_s) begin
                    state_nxt_s      = BUSY;
                    req_ready[win_s] = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY: begin
                if (cnt_r == CNT_W'(LAT - 1)) begin
                    state_nxt_s = RESP;
                end else begin
                    state_nxt_s = BUSY;
                end
            end
            RESP: begin
                if (rsp_valid_r && rsp_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State, pointer, captured operands, latency counter and registered response valid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            ptr_r       <= '0;
            id_r        <= '0;
            a_r         <= '0;
            b_r         <= '0;
            cnt_r       <= '0;
            rsp_valid_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if ((state_r == IDLE) && any_s) begin
                a_r   <= req_a[int'(win_s)*WIDTH +: WIDTH];
                b_r   <= req_b[int'(win_s)*WIDTH +: WIDTH];
                id_r  <= win_s;
                ptr_r <= (win_s == ID_W'(NREQ - 1)) ? '0 : win_s + ID_W'(1);
            end
            // Counter runs only in BUSY and wraps to zero as BUSY is left
            if (state_r == BUSY) begin
                cnt_r <= (cnt_r == CNT_W'(LAT - 1)) ? '0 : cnt_r + CNT_W'(1);
            end
            rsp_valid_r <= (state_nxt_s == RESP);
        end
    end

    // Operands stay constant from capture until the next grant, so the adder output
    // is already settled on entry to RESP and holds for the whole backpressure window.
    add_unit #(
        .WIDTH (WIDTH),
        .LAT   (LAT)
    ) u_add (
        .clk (clk),
        .rst (rst),
        .a   (a_r),
        .b   (b_r),
        .res (res_s)
    );

    assign rsp_valid = rsp_valid_r;
    assign rsp_sum   = res_s[WIDTH-1:0];
    assign rsp_carry = res_s[WIDTH];
    assign rsp_id    = id_r;
    assign busy      = (state_r != IDLE);

endmodule
